md_sequencer: RTL and testbench

- Issue/commit controller between the multicycle control unit and the mult_div unit.
- Latches operands, clears and starts the mult_div unit, and waits for its Done.
- Commits the result into architectural HI/LO registers and reports div-by-zero and timeout to control.
- Serves mfhi/mflo reads and mthi/mtlo writes.

---
 rtl/md_pkg.sv | 16 +
 rtl/md_sequencer.sv | 124 ++++++++++++
 tb/tb_md_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the mult_div issue/commit sequencer.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } md_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Value the mult_div unit drives on HI/LO after a divide by zero.
  localparam logic [31:0] MD_PARK_HI_LO = 32'h7FFF_FFFF;

endpackage

// File: rtl/md_sequencer.sv
// Issue/commit controller: latches operands, runs the mult_div unit, commits
// HI/LO, and serves mthi/mtlo writes while idle.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_hd_control,
  output logic        md_reset,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_divby0,
  input  logic        md_done
);

  localparam logic             WD_EN   = (MAX_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             wd_hit_s;

  // The unit runs only in RUN; any other state (and reset) parks it.
  assign md_reset = (state_r != RUN);

  // Watchdog limit reached in the current RUN cycle.
  always_comb begin
    wd_hit_s = 1'b0;
    if (WD_EN) begin
      wd_hit_s = (cnt_r == WD_LAST);
    end else begin
      wd_hit_s = 1'b0;
    end
  end

  // Sequencer state, operand latches, HI/LO and status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      hi            <= 32'd0;
      lo            <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      div_zero      <= 1'b0;
      timeout       <= 1'b0;
      md_a          <= 32'd0;
      md_b          <= 32'd0;
      md_hd_control <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      timeout  <= 1'b0;
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
          if (mthi) begin
            hi <= wdata;
          end
          if (mtlo) begin
            lo <= wdata;
          end
          if (start) begin
            state_r       <= CLEAR;
            busy          <= 1'b1;
            md_hd_control <= op;
            md_a          <= rs_val;
            md_b          <= rt_val;
          end
        end
        // One cycle in reset with HDControl already valid re-arms the unit.
        CLEAR: begin
          cnt_r   <= '0;
          state_r <= RUN;
        end
        RUN: begin
          if (md_done) begin
            // Divide by zero keeps the architectural HI/LO untouched.
            if ((md_hd_control == OP_DIV) && md_divby0) begin
              div_zero <= 1'b1;
            end else begin
              hi <= md_hi;
              lo <= md_lo;
            end
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (wd_hit_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: two instances (watchdog off / limit 16) driving a
// behavioural mult_div unit, table vectors, hand sequences and random ops.
module tb_md_sequencer;
  import md_pkg::*;

  localparam int WD_MAX = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  start;
  logic        op;
  logic [31:0] rs_val, rt_val, wdata;
  logic        mthi, mtlo;

  logic        busy [2];
  logic        done [2];
  logic        div_zero [2];
  logic        timeout [2];
  logic [31:0] hi [2];
  logic [31:0] lo [2];
  logic        md_hd_control [2];
  logic        md_reset [2];
  logic [31:0] md_a [2];
  logic [31:0] md_b [2];
  logic [31:0] md_hi [2];
  logic [31:0] md_lo [2];
  logic        md_divby0 [2];
  logic        md_done [2];
  longint      u_cnt [2];
  logic [63:0] u_res [2];

  logic [31:0] ref_hi [2];
  logic [31:0] ref_lo [2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  md_sequencer #(.MAX_CYCLES(0), .CNT_W(32)) dut0 (
    .clock(clock), .reset(reset), .start(start[0]), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .div_zero(div_zero[0]), .timeout(timeout[0]),
    .hi(hi[0]), .lo(lo[0]), .md_hd_control(md_hd_control[0]), .md_reset(md_reset[0]),
    .md_a(md_a[0]), .md_b(md_b[0]), .md_hi(md_hi[0]), .md_lo(md_lo[0]),
    .md_divby0(md_divby0[0]), .md_done(md_done[0])
  );

  md_sequencer #(.MAX_CYCLES(WD_MAX), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .div_zero(div_zero[1]), .timeout(timeout[1]),
    .hi(hi[1]), .lo(lo[1]), .md_hd_control(md_hd_control[1]), .md_reset(md_reset[1]),
    .md_a(md_a[1]), .md_b(md_b[1]), .md_hi(md_hi[1]), .md_lo(md_lo[1]),
    .md_divby0(md_divby0[1]), .md_done(md_done[1])
  );

  // Clock edges the unit needs out of reset before raising Done.
  function automatic longint unit_edges(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (o == OP_MULT) return 64'sd34;
    if (b == 32'd0) return 64'sd1;
    q = longint'(int'(a)) / longint'(int'(b));
    if (q < 0) q = -q;
    return q + 64'sd2;
  endfunction

  function automatic logic [63:0] unit_result(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    if (o == OP_MULT) begin
      p = longint'(int'(a)) * longint'(int'(b));
      return p;
    end
    if (b == 32'd0) return {MD_PARK_HI_LO, MD_PARK_HI_LO};
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return {r, q};
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) u_res[i] = unit_result(md_hd_control[i], md_a[i], md_b[i]);
  end

  // Behavioural mult_div unit; DivBy0 is only cleared by a reset in div mode.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (md_reset[i] === 1'b1) begin
        u_cnt[i]   <= 0;
        md_done[i] <= 1'b0;
        if (md_hd_control[i] !== OP_MULT) md_divby0[i] <= 1'b0;
      end else begin
        u_cnt[i] <= u_cnt[i] + 1;
        if (u_cnt[i] == unit_edges(md_hd_control[i], md_a[i], md_b[i]) - 1) begin
          md_done[i] <= 1'b1;
          md_hi[i]   <= u_res[i][63:32];
          md_lo[i]   <= u_res[i][31:0];
          if (md_hd_control[i] == OP_DIV) md_divby0[i] <= (md_b[i] == 32'd0);
        end
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // IDLE write of HI and/or LO, then check both instances.
  task automatic wr(input logic h, input logic l, input logic [31:0] d);
    @(posedge clock); #1;
    mthi = h; mtlo = l; wdata = d;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (h) ref_hi[i] = d;
      if (l) ref_lo[i] = d;
    end
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk32("wr_hi", hi[i], ref_hi[i]);
      chk32("wr_lo", lo[i], ref_lo[i]);
    end
  endtask

  // Expected outcome of one operation from the architectural rules.
  task automatic predict(input int u, input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic wh, input logic wl, input logic [31:0] wd,
                         output int lat, output logic dz, output logic to,
                         output logic [31:0] eh, output logic [31:0] el);
    logic [31:0] h0, l0;
    longint      p;
    int          q;
    h0 = wh ? wd : ref_hi[u];
    l0 = wl ? wd : ref_lo[u];
    dz = 1'b0;
    to = 1'b0;
    if (o == OP_MULT) begin
      p = longint'(int'(a)) * longint'(int'(b));
      lat = 37; eh = p[63:32]; el = p[31:0];
    end else if (b == 32'd0) begin
      lat = 4; dz = 1'b1; eh = h0; el = l0;
    end else begin
      q = int'(a) / int'(b);
      el = q;
      eh = int'(a) % int'(b);
      lat = ((q < 0) ? -q : q) + 5;
    end
    if (u == 1 && lat > WD_MAX + 2) begin
      lat = WD_MAX + 2; to = 1'b1; dz = 1'b0; eh = h0; el = l0;
    end
  endtask

  task automatic run_op(input int u, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic wh, input logic wl, input logic [31:0] wd, input int poke,
                        input int e_lat, input logic e_dz, input logic e_to,
                        input logic [31:0] e_hi, input logic [31:0] e_lo);
    int t0, lat, busy_n;
    bit seen;
    @(posedge clock); #1;
    t0 = cyc;
    start[u] = 1'b1; op = o; rs_val = a; rt_val = b; mthi = wh; mtlo = wl; wdata = wd;
    @(posedge clock); #1;
    start[u] = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    if (wh) ref_hi[1-u] = wd;
    if (wl) ref_lo[1-u] = wd;
    seen = 0; busy_n = 0; lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      if (done[u]) begin
        seen = 1;
        lat = cyc - t0;
        break;
      end
      if (busy[u]) busy_n++;
      if (n == 1) begin
        chk32("md_a", md_a[u], a);
        chk32("md_b", md_b[u], b);
        chk1("md_hd_control", md_hd_control[u], o);
        chk1("md_reset_clear", md_reset[u], 1'b1);
      end
      if (n == 2) chk1("md_reset_run", md_reset[u], 1'b0);
      if (poke != 0 && n == poke) begin
        start[u] = 1'b1; mthi = 1'b1; wdata = 32'hA5A5_A5A5;
        ref_hi[1-u] = 32'hA5A5_A5A5;
      end else if (poke != 0 && n == poke + 1) begin
        start[u] = 1'b0; mthi = 1'b0;
      end
    end
    start[u] = 1'b0; mthi = 1'b0;
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_wait: no done within 300 cycles, required latency %0d", e_lat);
    end else begin
      chk32("latency", lat, e_lat);
      chk32("busy_cycles", busy_n, e_lat - 1);
      chk1("busy_at_done", busy[u], 1'b0);
      chk1("div_zero", div_zero[u], e_dz);
      chk1("timeout", timeout[u], e_to);
      chk32("hi", hi[u], e_hi);
      chk32("lo", lo[u], e_lo);
      chk1("md_reset_idle", md_reset[u], 1'b1);
      @(negedge clock);
      chk1("done_pulse", done[u], 1'b0);
      chk1("div_zero_pulse", div_zero[u], 1'b0);
      chk1("timeout_pulse", timeout[u], 1'b0);
    end
    ref_hi[u] = e_hi;
    ref_lo[u] = e_lo;
  endtask

  typedef struct {
    int          u;
    logic        op;
    logic [31:0] a, b;
    logic        pre;
    logic [31:0] pre_hi, pre_lo;
    logic        wh, wl;
    logic [31:0] wd;
    int          lat;
    logic        dz, to;
    logic [31:0] ehi, elo;
  } vec_t;

  vec_t        tbl [6];
  int          lat, extra;
  logic        dz, to, o, wh, wl;
  logic [31:0] eh, el, a, b, wd;
  int          bm, q0, ai;

  initial begin
    tbl[0] = '{0, OP_MULT, 32'd6, 32'hFFFF_FFF9, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0,
               37, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    tbl[1] = '{0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0,
               8, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[2] = '{0, OP_DIV, 32'd10, 32'd0, 1'b1, 32'd5, 32'd9, 1'b0, 1'b0, 32'd0,
               4, 1'b1, 1'b0, 32'd5, 32'd9};
    tbl[3] = '{1, OP_DIV, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h1234, 32'h5678, 1'b0, 1'b0, 32'd0,
               18, 1'b0, 1'b1, 32'h1234, 32'h5678};
    tbl[4] = '{0, OP_DIV, 32'd10, 32'd0, 1'b1, 32'd5, 32'd9, 1'b1, 1'b0, 32'hCAFE_F00D,
               4, 1'b1, 1'b0, 32'hCAFE_F00D, 32'd9};
    tbl[5] = '{0, OP_MULT, 32'h8000_0000, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1357,
               37, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0};

    reset = 1'b0; start = 2'b00; op = 1'b0; rs_val = 32'd0; rt_val = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      ref_hi[i] = 32'd0; ref_lo[i] = 32'd0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk1("rst_busy", busy[i], 1'b0);
      chk1("rst_done", done[i], 1'b0);
      chk32("rst_hi", hi[i], 32'd0);
      chk32("rst_lo", lo[i], 32'd0);
      chk1("rst_md_reset", md_reset[i], 1'b1);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      if (tbl[k].pre) begin
        wr(1'b1, 1'b0, tbl[k].pre_hi);
        wr(1'b0, 1'b1, tbl[k].pre_lo);
      end
      run_op(tbl[k].u, tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].wh, tbl[k].wl, tbl[k].wd, 0,
             tbl[k].lat, tbl[k].dz, tbl[k].to, tbl[k].ehi, tbl[k].elo);
    end

    // Start and mthi while busy are ignored; only one done is produced.
    predict(0, OP_MULT, 32'd11, 32'hFFFF_FFF3, 1'b0, 1'b0, 32'd0, lat, dz, to, eh, el);
    run_op(0, OP_MULT, 32'd11, 32'hFFFF_FFF3, 1'b0, 1'b0, 32'd0, 10, lat, dz, to, eh, el);
    extra = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clock);
      if (done[0]) extra++;
    end
    chk32("extra_done", extra, 0);
    wr(1'b1, 1'b0, 32'hA5A5_A5A5);
    chk32("mthi_idle", hi[0], 32'hA5A5_A5A5);

    for (int k = 0; k < 24; k++) begin
      o  = 1'($urandom_range(0, 1));
      wh = ($urandom_range(0, 3) == 0);
      wl = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (o == OP_MULT) begin
        a = $urandom; b = $urandom;
      end else if ($urandom_range(0, 5) == 0) begin
        a = $urandom; b = 32'd0;
      end else begin
        bm = int'($urandom_range(1, 500));
        q0 = int'($urandom_range(0, 30));
        ai = bm * q0 + int'($urandom_range(0, 32'(bm - 1)));
        if ($urandom_range(0, 1) == 1) ai = -ai;
        a = ai;
        b = ($urandom_range(0, 1) == 1) ? -bm : bm;
      end
      predict(k % 3 == 2 ? 1 : 0, o, a, b, wh, wl, wd, lat, dz, to, eh, el);
      run_op(k % 3 == 2 ? 1 : 0, o, a, b, wh, wl, wd, 0, lat, dz, to, eh, el);
      if ($urandom_range(0, 3) == 0) wr(1'($urandom_range(0, 1)), 1'b1, $urandom);
    end

    // Asynchronous reset in RUN cycle 10 of a mult.
    wr(1'b1, 1'b1, 32'h1111_1111);
    @(posedge clock); #1;
    ai = cyc;
    start[0] = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clock); #1;
    start[0] = 1'b0;
    while (cyc < ai + 11) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk1("arst_busy", busy[i], 1'b0);
      chk1("arst_done", done[i], 1'b0);
      chk32("arst_hi", hi[i], 32'd0);
      chk32("arst_lo", lo[i], 32'd0);
      chk32("arst_md_a", md_a[i], 32'd0);
      chk32("arst_md_b", md_b[i], 32'd0);
      chk1("arst_md_hd", md_hd_control[i], 1'b0);
      chk1("arst_md_reset", md_reset[i], 1'b1);
      ref_hi[i] = 32'd0; ref_lo[i] = 32'd0;
    end
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done[0]) extra++;
    end
    chk32("arst_no_done", extra, 0);
    predict(0, OP_MULT, 32'hFFFF_FFFB, 32'd7, 1'b0, 1'b0, 32'd0, lat, dz, to, eh, el);
    run_op(0, OP_MULT, 32'hFFFF_FFFB, 32'd7, 1'b0, 1'b0, 32'd0, 0, lat, dz, to, eh, el);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
